// File: rtl/pc_sequencer.sv
// Fetch PC, branch/call/return redirect and circular return-address stack for RIPTIDE-II.
// Define PC_STACK_GUARD_EN to enable occupancy tracking and the sticky stack_err flag.
module pc_sequencer #(
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        n_RST,
    input  logic        hazard,
    input  logic        p_cache_miss,
    input  logic        PC_JMP,
    input  logic        PC_XEC,
    input  logic        PC_NZT,
    input  logic        PC_CALL,
    input  logic        PC_RET,
    input  logic [12:0] PC_I_field,
    input  logic        long_I,
    input  logic [7:0]  alu_data,
    input  logic        alu_nz,
    output logic [15:0] PC_out,
    output logic        squash,
    output logic        stack_err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH);
    localparam int unsigned CNT_W = SP_W + 1;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_RET, SEL_CALL, SEL_JMP, SEL_XEC, SEL_NZT
    } sel_t;

    logic [15:0]     stack_mem [STACK_DEPTH];
    logic [15:0]     pc_p0, pc_p1, pc_p2, xec_ret;
    logic [1:0]      squash_cnt;
    logic            xec_pend;
    logic [SP_W-1:0] sp;

    logic [15:0]     nxt_pc, nxt_p0, nxt_p1, nxt_p2, nxt_xret, target, exec_pc, pop_data;
    logic [1:0]      nxt_cnt;
    logic            nxt_xp, push_en;
    logic [SP_W-1:0] nxt_sp, sp_dec;
    sel_t            sel;

`ifdef PC_STACK_GUARD_EN
    logic [CNT_W-1:0] count, nxt_count;
    logic             err_q, nxt_err;
    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

    assign exec_pc  = pc_p2;
    assign sp_dec   = sp - SP_W'(1);
    assign pop_data = stack_mem[sp_dec];

    // Control arbitration: only one control acts, and only outside stall and squash.
    always_comb begin
        sel = SEL_NONE;
        if (!hazard && squash_cnt == 2'd0) begin
            if (PC_RET)                sel = SEL_RET;
            else if (PC_CALL)          sel = SEL_CALL;
            else if (PC_JMP)           sel = SEL_JMP;
            else if (PC_XEC)           sel = SEL_XEC;
            else if (PC_NZT && alu_nz) sel = SEL_NZT;
        end
    end

    // Next-state computation; every register holds by default.
    always_comb begin
        nxt_pc   = PC_out;
        nxt_p0   = pc_p0;
        nxt_p1   = pc_p1;
        nxt_p2   = pc_p2;
        nxt_xret = xec_ret;
        nxt_cnt  = squash_cnt;
        nxt_xp   = xec_pend;
        nxt_sp   = sp;
        push_en  = 1'b0;
        target   = 16'h0000;
`ifdef PC_STACK_GUARD_EN
        nxt_count = count;
        nxt_err   = err_q;
`endif
        case (sel)
            SEL_RET: begin
`ifdef PC_STACK_GUARD_EN
                if (count == CNT_W'(0)) begin
                    nxt_err = 1'b1;
                end else begin
                    target    = pop_data;
                    nxt_sp    = sp_dec;
                    nxt_count = count - CNT_W'(1);
                end
`else
                target = pop_data;
                nxt_sp = sp_dec;
`endif
            end
            SEL_CALL: begin
                target  = {exec_pc[15:13], PC_I_field};
                push_en = 1'b1;
                nxt_sp  = sp + SP_W'(1);
`ifdef PC_STACK_GUARD_EN
                // A full stack overwrites its oldest entry; occupancy saturates.
                if (count == CNT_W'(STACK_DEPTH)) nxt_err = 1'b1;
                else                              nxt_count = count + CNT_W'(1);
`endif
            end
            SEL_JMP: target = long_I ? {exec_pc[15:13], PC_I_field} : {exec_pc[15:8], alu_data};
            SEL_XEC: begin
                target   = {exec_pc[15:8], alu_data};
                nxt_xret = exec_pc + 16'd1;
            end
            SEL_NZT: target = {exec_pc[15:8], alu_data};
            default: target = 16'h0000;
        endcase

        if (sel != SEL_NONE) begin
            nxt_pc  = target;
            nxt_cnt = 2'd2;
            nxt_xp  = (sel == SEL_XEC);
        end else if (!hazard && !p_cache_miss) begin
            nxt_p0 = PC_out;
            nxt_p1 = pc_p0;
            nxt_p2 = pc_p1;
            nxt_pc = xec_pend ? xec_ret : PC_out + 16'd1;
            nxt_xp = 1'b0;
            if (squash_cnt != 2'd0) nxt_cnt = squash_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_RST) begin
            PC_out     <= 16'h0000;
            pc_p0      <= 16'h0000;
            pc_p1      <= 16'h0000;
            pc_p2      <= 16'h0000;
            xec_ret    <= 16'h0000;
            squash_cnt <= 2'd0;
            squash     <= 1'b0;
            xec_pend   <= 1'b0;
            sp         <= '0;
`ifdef PC_STACK_GUARD_EN
            count      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            PC_out     <= nxt_pc;
            pc_p0      <= nxt_p0;
            pc_p1      <= nxt_p1;
            pc_p2      <= nxt_p2;
            xec_ret    <= nxt_xret;
            squash_cnt <= nxt_cnt;
            squash     <= (nxt_cnt != 2'd0);
            xec_pend   <= nxt_xp;
            sp         <= nxt_sp;
`ifdef PC_STACK_GUARD_EN
            count      <= nxt_count;
            err_q      <= nxt_err;
`endif
        end
    end

    // Stack RAM is not reset; contents survive n_RST.
    always_ff @(posedge clk) begin
        if (n_RST && push_en) stack_mem[sp] <= exec_pc + 16'd1;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan sequences plus random stimulus vs a queue-based model.
module tb_pc_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_RST, hazard, p_cache_miss;
    logic        PC_JMP, PC_XEC, PC_NZT, PC_CALL, PC_RET;
    logic [12:0] PC_I_field;
    logic        long_I;
    logic [7:0]  alu_data;
    logic        alu_nz;
    logic [15:0] PC_out;
    logic        squash, stack_err;

    int total = 0;
    int bad   = 0;

    pc_sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .n_RST(n_RST), .hazard(hazard), .p_cache_miss(p_cache_miss),
        .PC_JMP(PC_JMP), .PC_XEC(PC_XEC), .PC_NZT(PC_NZT), .PC_CALL(PC_CALL), .PC_RET(PC_RET),
        .PC_I_field(PC_I_field), .long_I(long_I), .alu_data(alu_data), .alu_nz(alu_nz),
        .PC_out(PC_out), .squash(squash), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Reference model: fetch history, pending squash slots, XEC return and a return-address list.
    logic [15:0] m_pc;
    logic [15:0] m_hist[$];
    int          m_sq;
    bit          m_xp;
    logic [15:0] m_xret;
    logic [15:0] m_stk[$];
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [15:0] ex, tgt;
        bit taken, is_xec;
        if (!n_RST) begin
            m_pc = 16'h0; m_hist = '{16'h0, 16'h0, 16'h0};
            m_sq = 0; m_xp = 0; m_xret = 16'h0; m_err = 0;
            m_stk.delete();
            return;
        end
        if (hazard) return;
        ex = m_hist[2]; taken = 0; is_xec = 0; tgt = 16'h0;
        if (m_sq == 0) begin
            if (PC_RET) begin
                taken = 1;
                if (m_stk.size() == 0) begin
                    tgt = 16'h0;
`ifdef PC_STACK_GUARD_EN
                    m_err = 1;
`endif
                end else tgt = m_stk.pop_back();
            end else if (PC_CALL) begin
                taken = 1;
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
`ifdef PC_STACK_GUARD_EN
                    m_err = 1;
`endif
                end
                m_stk.push_back(ex + 16'd1);
                tgt = {ex[15:13], PC_I_field};
            end else if (PC_JMP) begin
                taken = 1;
                tgt = long_I ? {ex[15:13], PC_I_field} : {ex[15:8], alu_data};
            end else if (PC_XEC) begin
                taken = 1; is_xec = 1;
                tgt = {ex[15:8], alu_data};
            end else if (PC_NZT && alu_nz) begin
                taken = 1;
                tgt = {ex[15:8], alu_data};
            end
        end
        if (taken) begin
            m_pc = tgt; m_sq = 2; m_xp = is_xec;
            if (is_xec) m_xret = ex + 16'd1;
        end else if (!p_cache_miss) begin
            m_hist.push_front(m_pc);
            void'(m_hist.pop_back());
            m_pc = m_xp ? m_xret : m_pc + 16'd1;
            m_xp = 0;
            if (m_sq > 0) m_sq--;
        end
    endtask

    // One clock: model follows the edge, outputs compared at the following negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("pc", 32'(PC_out), 32'(m_pc));
        chk("squash", 32'(squash), 32'(m_sq != 0));
        chk("stack_err", 32'(stack_err), 32'(m_err));
    endtask

    task automatic drive(input logic j, input logic x, input logic n, input logic c, input logic r);
        PC_JMP = j; PC_XEC = x; PC_NZT = n; PC_CALL = c; PC_RET = r;
        hazard = 1'b0; p_cache_miss = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
        step();
    endtask

    // Land exec_pc on addr with squash clear (addr below 16'h2000, exec_pc upper bits zero).
    task automatic go_to(input logic [15:0] addr);
        idle(); idle();
        drive(1, 0, 0, 0, 0); long_I = 1'b1; PC_I_field = addr[12:0];
        step();
        idle(); idle(); idle();
    endtask

    initial begin
        logic [15:0] ret_exp;
        int r;
        n_RST = 1'b0; long_I = 1'b0; PC_I_field = '0; alu_data = '0; alu_nz = 1'b0;
        drive(0, 0, 0, 0, 0);
        m_hist = '{16'h0, 16'h0, 16'h0};
        step(); step();
        chk("rst_pc", 32'(PC_out), 32'h0);
        chk("rst_squash", 32'(squash), 32'h0);
        chk("rst_err", 32'(stack_err), 32'h0);
        n_RST = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("seq_pc", 32'(PC_out), 32'(i));
        end

        drive(1, 0, 0, 0, 0); long_I = 1'b1; PC_I_field = 13'h0ABC;
        step();
        chk("jmp_long", 32'(PC_out), 32'h0ABC);
        chk("jmp_squash1", 32'(squash), 32'h1);
        PC_I_field = 13'h0111;
        step();
        chk("jmp_ignored", 32'(PC_out), 32'h0ABD);
        chk("jmp_squash2", 32'(squash), 32'h1);
        idle();
        chk("jmp_squash_end", 32'(squash), 32'h0);

        go_to(16'h0100);
        drive(0, 0, 0, 1, 0); PC_I_field = 13'h0400;
        step();
        chk("call_tgt", 32'(PC_out), 32'h0400);
        idle(); idle(); idle();
        drive(0, 0, 0, 0, 1);
        step();
        chk("ret_tgt", 32'(PC_out), 32'h0101);

        go_to(16'h0300);
        drive(0, 1, 0, 0, 0); alu_data = 8'h40;
        step();
        chk("xec_tgt", 32'(PC_out), 32'h0340);
        idle();
        chk("xec_ret", 32'(PC_out), 32'h0301);

        go_to(16'h1280);
        drive(0, 0, 1, 0, 0); alu_data = 8'h22; alu_nz = 1'b0;
        step();
        chk("nzt_not_taken", 32'(PC_out), 32'h1284);
        go_to(16'h1280);
        drive(0, 0, 1, 0, 0); alu_nz = 1'b1;
        step();
        chk("nzt_taken", 32'(PC_out), 32'h1222);

        go_to(16'h0050);
        drive(1, 0, 0, 0, 0); PC_I_field = 13'h0777; hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hazard_hold", 32'(PC_out), 32'h0053);
        end
        hazard = 1'b0;
        step();
        chk("hazard_release", 32'(PC_out), 32'h0777);

        // Five nested CALLs into a depth-4 stack, then unwind.
        go_to(16'h0100);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 0); PC_I_field = 13'(16'h0200 + k * 16'h20);
            step();
            idle(); idle(); idle();
        end
`ifdef PC_STACK_GUARD_EN
        chk("overflow_err", 32'(stack_err), 32'h1);
`else
        chk("no_guard_err", 32'(stack_err), 32'h0);
`endif
        for (int k = 4; k >= 1; k--) begin
            drive(0, 0, 0, 0, 1);
            step();
            ret_exp = 16'h0200 + 16'(k - 1) * 16'h20 + 16'd1;
            chk("ret_chain", 32'(PC_out), 32'(ret_exp));
            idle(); idle(); idle();
        end
`ifdef PC_STACK_GUARD_EN
        drive(0, 0, 0, 0, 1);
        step();
        chk("underflow_tgt", 32'(PC_out), 32'h0);
        chk("underflow_err", 32'(stack_err), 32'h1);
`endif

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            drive(0, 0, 0, 0, 0);
            if (r >= 50 && r < 90) begin
                case ($urandom_range(0, 4))
                    0: PC_JMP  = 1'b1;
                    1: PC_XEC  = 1'b1;
                    2: PC_NZT  = 1'b1;
                    3: PC_CALL = 1'b1;
                    default: PC_RET = 1'b1;
                endcase
            end else if (r >= 90) begin
                {PC_JMP, PC_XEC, PC_NZT, PC_CALL, PC_RET} = 5'($urandom);
            end
`ifndef PC_STACK_GUARD_EN
            if (m_stk.size() == 0) PC_RET = 1'b0;
`endif
            hazard       = ($urandom_range(0, 99) < 15);
            p_cache_miss = ($urandom_range(0, 99) < 15);
            n_RST        = ($urandom_range(0, 199) != 0);
            long_I       = 1'($urandom);
            alu_nz       = 1'($urandom);
            alu_data     = 8'($urandom);
            PC_I_field   = 13'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
